// File: rtl/cpu_nios_pio_pkg.sv
// Shared constants for the Nios II push-button PIO: register word addresses
// and the default debounce interval.
package cpu_nios_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE     = 2'd3;

    // 1 ms of stability at a 50 MHz clock.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/cpu_nios_debounce.sv
// One push-button channel: two-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse that fires on the clock edge where
// the debounced level is about to rise.
module cpu_nios_debounce
    import cpu_nios_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_s;

    // Next-state logic: count consecutive disagreeing cycles; the last one
    // of the run flips the stable level and, for a 0->1 flip, raises rise_s
    // so the edge is captured on the same clock as the level update.
    always_comb begin
        sync1_d  = din;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = CNT_ZERO;
        rise_s   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = CNT_ZERO;
                rise_s   = sync2_q;
            end else begin
                stable_d = stable_q;
                cnt_d    = cnt_q + CNT_ONE;
                rise_s   = 1'b0;
            end
        end else begin
            stable_d = stable_q;
            cnt_d    = CNT_ZERO;
            rise_s   = 1'b0;
        end
    end

    // State registers with synchronous reset; reset discards any partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= CNT_ZERO;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_s;

endmodule

// File: rtl/cpu_nios_keys_pio.sv
// Avalon-MM push-button PIO for Nios II: debounced inputs, rising-edge
// capture with write-1-to-clear, interrupt mask and a registered level irq.
module cpu_nios_keys_pio
    import cpu_nios_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] wdata_s;
    logic [WIDTH-1:0] clr_s;
    logic             wr_s;
    logic             writedata_unused_s;

    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             irq_q, irq_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_db
            cpu_nios_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .din    (in_port[gi]),
                .stable (stable_s[gi]),
                .rise   (rise_s[gi])
            );
        end
    endgenerate

    // Upper write-data bits have no destination.
    assign writedata_unused_s = ^writedata;

    // Bus write decode and register next-state; a fresh edge beats a
    // simultaneous clear, and irq looks only at registered state.
    always_comb begin
        wr_s    = chipselect & ~write_n;
        wdata_s = writedata[WIDTH-1:0];
        mask_d  = mask_q;
        clr_s   = {WIDTH{1'b0}};
        if (wr_s) begin
            case (address)
                ADDR_IRQ_MASK: mask_d = wdata_s;
                ADDR_EDGE:     clr_s  = wdata_s;
                default: begin
                    mask_d = mask_q;
                    clr_s  = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            mask_d = mask_q;
            clr_s  = {WIDTH{1'b0}};
        end
        edge_d = (edge_q & ~clr_s) | rise_s;
        irq_d  = |(edge_q & mask_q);
    end

    // Register state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= {WIDTH{1'b0}};
            edge_q <= {WIDTH{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    // Zero-latency read mux, zero-extended; reads have no side effects.
    always_comb begin
        readdata = 32'd0;
        case (address)
            ADDR_DATA:     readdata = 32'(stable_s);
            ADDR_RSVD:     readdata = 32'd0;
            ADDR_IRQ_MASK: readdata = 32'(mask_q);
            ADDR_EDGE:     readdata = 32'(edge_q);
            default:       readdata = 32'd0;
        endcase
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_cpu_nios_keys_pio.sv
module tb_cpu_nios_keys_pio;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int NCYC = 8192;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   address;
    logic         chipselect;
    logic         write_n;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic [W-1:0] in_port;
    logic         irq;

    always #10 clk = ~clk;

    cpu_nios_keys_pio #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Per-edge history of what the bench applied: button levels and reset.
    logic [W-1:0] in_h  [0:NCYC-1];
    logic         rst_h [0:NCYC-1];

    logic [W-1:0] m_stable = '0;
    logic [W-1:0] m_edge   = '0;
    logic [W-1:0] m_mask   = '0;
    logic         m_irq    = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", nm, cyc, got, exp);
        end
    endtask

    // Value the button logic sees at edge e: the input level from two edges
    // earlier, unless a reset landed in between.
    function automatic logic seen_at(int e, int b);
        if (e < 2) return 1'b0;
        if (rst_h[e-1] || rst_h[e-2]) return 1'b0;
        return in_h[e-2][b];
    endfunction

    // A bit's level flips at edge k when the last D seen values, with no
    // reset among them, all disagree with the current level.
    function automatic logic [W-1:0] settle(int k, logic [W-1:0] cur);
        logic [W-1:0] nxt;
        logic v;
        logic ok;
        int e;
        nxt = cur;
        for (int b = 0; b < W; b++) begin
            v  = ~cur[b];
            ok = 1'b1;
            for (int j = 0; j < D; j++) begin
                e = k - j;
                if (e < 2) ok = 1'b0;
                else if (j > 0 && rst_h[e]) ok = 1'b0;
                else if (seen_at(e, b) != v) ok = 1'b0;
            end
            if (ok) nxt[b] = v;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] exp_rd(logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_stable);
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_edge);
            default: return 32'd0;
        endcase
    endfunction

    // Reference model, advanced on every rising edge.
    initial begin
        logic [W-1:0] nxt;
        logic [W-1:0] clr;
        logic         irq_n;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_stable = '0;
                m_edge   = '0;
                m_mask   = '0;
                m_irq    = 1'b0;
            end else begin
                nxt   = settle(cyc, m_stable);
                clr   = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
                irq_n = |(m_edge & m_mask);
                if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
                m_edge   = (m_edge & ~clr) | (nxt & ~m_stable);
                m_stable = nxt;
                m_irq    = irq_n;
            end
            in_h[cyc]  = in_port;
            rst_h[cyc] = reset;
            cyc++;
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("irq_model", 32'(irq), 32'(m_irq));
                chk("readdata_model", readdata, exp_rd(address));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rdchk(string nm, logic [1:0] a, logic [31:0] exp);
        address = a;
        #1;
        chk(nm, readdata, exp);
    endtask

    initial begin
        reset      = 1'b1;
        in_port    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'd0;
        repeat (3) tick();
        rdchk("rst_data", 2'd0, 32'h0);
        rdchk("rst_rsvd", 2'd1, 32'h0);
        rdchk("rst_mask", 2'd2, 32'h0);
        rdchk("rst_edge", 2'd3, 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        tick();

        // register map
        wr(2'd0, 32'hFFFF_FFFF);
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFFF);
        rdchk("map_data", 2'd0, 32'h0);
        rdchk("map_rsvd", 2'd1, 32'h0);
        rdchk("map_mask", 2'd2, 32'hF);
        wr(2'd2, 32'h0);

        // bounce rejection
        for (int i = 0; i < 4; i++) begin
            in_port[0] = (i % 2 == 0);
            repeat (2) tick();
        end
        in_port = '0;
        repeat (8) tick();
        rdchk("bounce_data", 2'd0, 32'h0);
        rdchk("bounce_edge", 2'd3, 32'h0);
        chk("bounce_irq", 32'(irq), 32'd0);

        // clean press
        wr(2'd2, 32'h1);
        in_port = 4'h1;
        repeat (5) tick();
        rdchk("press_data_c5", 2'd0, 32'h0);
        tick();
        rdchk("press_data_c6", 2'd0, 32'h1);
        rdchk("press_edge_c6", 2'd3, 32'h1);
        chk("press_irq_c6", 32'(irq), 32'd0);
        tick();
        chk("press_irq_c7", 32'(irq), 32'd1);
        wr(2'd3, 32'h1);
        rdchk("w1c_edge", 2'd3, 32'h0);
        chk("w1c_irq_same", 32'(irq), 32'd1);
        tick();
        chk("w1c_irq_drop", 32'(irq), 32'd0);
        in_port = '0;
        repeat (8) tick();
        rdchk("fall_edge", 2'd3, 32'h0);
        rdchk("fall_data", 2'd0, 32'h0);

        // masked pending edge
        wr(2'd2, 32'h0);
        in_port = 4'h4;
        repeat (8) tick();
        rdchk("pend_edge", 2'd3, 32'h4);
        chk("pend_irq", 32'(irq), 32'd0);
        wr(2'd2, 32'h4);
        tick();
        chk("pend_irq_unmask", 32'(irq), 32'd1);
        wr(2'd3, 32'h4);
        in_port = '0;
        repeat (8) tick();
        chk("pend_irq_clr", 32'(irq), 32'd0);

        // set wins over a simultaneous clear
        in_port = 4'h8;
        repeat (5) tick();
        wr(2'd3, 32'h8);
        rdchk("setwin_edge", 2'd3, 32'h8);
        rdchk("setwin_data", 2'd0, 32'h8);
        wr(2'd3, 32'h8);
        rdchk("setwin_clr", 2'd3, 32'h0);
        in_port = '0;
        repeat (8) tick();

        // reset mid-debounce, button held through release
        in_port = 4'h2;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rdchk("rstmid_data", 2'd0, 32'h0);
        rdchk("rstmid_mask", 2'd2, 32'h0);
        rdchk("rstmid_edge", 2'd3, 32'h0);
        chk("rstmid_irq", 32'(irq), 32'd0);
        repeat (5) tick();
        rdchk("rstmid_data_c5", 2'd0, 32'h0);
        tick();
        rdchk("rstmid_data_c6", 2'd0, 32'h2);
        rdchk("rstmid_edge_c6", 2'd3, 32'h2);
        in_port = '0;
        repeat (8) tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) in_port = W'($urandom);
            reset      = ($urandom_range(0, 399) == 0);
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 3) != 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            tick();
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
